// File: rtl/pipe_controller_md.sv
// Control path for a 5-stage RV32IM pipeline: D-stage decode, E/M/W control
// registers, branch resolution in E and a hold timer for multi-cycle mul/div.
//
// state | meaning
// IDLE  | no long op in progress; a mul/div with latency > 1 arriving in E starts the timer
// BUSY  | long op occupying E; cnt holds the extra cycles still needed, counting down to 0
module pipe_controller_md #(
  parameter int DIV_LATENCY = 8,
  parameter int MUL_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       ZeroE,
  input  logic       LtE,
  input  logic       LtuE,
  input  logic       StallE,
  input  logic       FlushE,
  output logic [2:0] ImmSrcD,
  output logic [4:0] ALUControlE,
  output logic       ALUSrcAE,
  output logic [1:0] ALUSrcBE,
  output logic       ResultSrcE0,
  output logic       PCSrcE,
  output logic       PCJalSrcE,
  output logic       MulDivE,
  output logic       BusyE,
  output logic       MemWriteM,
  output logic       RegWriteM,
  output logic       RegWriteW,
  output logic [1:0] ResultSrcW
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [5:0] DIV_L = 6'(DIV_LATENCY);
  localparam logic [5:0] MUL_L = 6'(MUL_LATENCY);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       jump;
    logic       branch;
    logic       jalr;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic [4:0] aluControl;
    logic [2:0] funct3;
  } ctrl_t;

  ctrl_t      ctrlD, ctrlE;
  logic [2:0] immSrcD;
  logic       isMulDiv;
  logic       altD;
  logic [1:0] resultSrcM;
  logic       branchCond;
  logic [5:0] latE;
  logic       longOpE;
  state_t     state, stateNext;
  logic [4:0] cnt, cntNext;

  // D-stage decode; unknown opcodes fall through as an all-zero bubble
  always_comb begin
    ctrlD    = '0;
    immSrcD  = 3'b000;
    isMulDiv = (funct7 == 7'b0000001);
    altD     = 1'b0;
    case (op)
      OP_R: begin
        altD             = funct7[5] & ((funct3 == 3'b000) | (funct3 == 3'b101));
        ctrlD.regWrite   = 1'b1;
        ctrlD.aluControl = {isMulDiv, altD, funct3};
        ctrlD.funct3     = funct3;
      end
      OP_IALU: begin
        altD             = funct7[5] & (funct3 == 3'b101);
        ctrlD.regWrite   = 1'b1;
        ctrlD.aluSrcB    = 2'b01;
        ctrlD.aluControl = {1'b0, altD, funct3};
        ctrlD.funct3     = funct3;
      end
      OP_LOAD: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.aluSrcB   = 2'b01;
        ctrlD.resultSrc = 2'b01;
        ctrlD.funct3    = funct3;
      end
      OP_STORE: begin
        ctrlD.memWrite = 1'b1;
        ctrlD.aluSrcB  = 2'b01;
        ctrlD.funct3   = funct3;
        immSrcD        = 3'b001;
      end
      OP_BR: begin
        ctrlD.branch     = 1'b1;
        ctrlD.aluControl = 5'b01000;
        ctrlD.funct3     = funct3;
        immSrcD          = 3'b010;
      end
      OP_JAL: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.jump      = 1'b1;
        ctrlD.aluSrcA   = 1'b1;
        ctrlD.aluSrcB   = 2'b01;
        ctrlD.resultSrc = 2'b10;
        immSrcD         = 3'b011;
      end
      OP_JALR: begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.jump      = 1'b1;
        ctrlD.jalr      = 1'b1;
        ctrlD.aluSrcB   = 2'b01;
        ctrlD.resultSrc = 2'b10;
        ctrlD.funct3    = funct3;
      end
      OP_LUI: begin
        ctrlD.regWrite = 1'b1;
        ctrlD.aluSrcB  = 2'b10;
        immSrcD        = 3'b100;
      end
      OP_AUIPC: begin
        ctrlD.regWrite = 1'b1;
        ctrlD.aluSrcA  = 1'b1;
        ctrlD.aluSrcB  = 2'b01;
        immSrcD        = 3'b100;
      end
      default: ctrlD = '0;
    endcase
  end

  assign ImmSrcD = immSrcD;

  // E register: reset, then flush to bubble, then hold while stalled or busy
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrlE <= '0;
    end else if (FlushE) begin
      ctrlE <= '0;
    end else if (!(StallE || BusyE)) begin
      ctrlE <= ctrlD;
    end
  end

  assign ALUControlE = ctrlE.aluControl;
  assign ALUSrcAE    = ctrlE.aluSrcA;
  assign ALUSrcBE    = ctrlE.aluSrcB;
  assign ResultSrcE0 = ctrlE.resultSrc[0];
  assign MulDivE     = ctrlE.aluControl[4];

  // Branch condition from the registered funct3, so a changing D stage cannot disturb it
  always_comb begin
    case (ctrlE.funct3)
      3'b000:  branchCond = ZeroE;
      3'b001:  branchCond = ~ZeroE;
      3'b100:  branchCond = LtE;
      3'b101:  branchCond = ~LtE;
      3'b110:  branchCond = LtuE;
      3'b111:  branchCond = ~LtuE;
      default: branchCond = 1'b0;
    endcase
  end

  assign PCSrcE    = (ctrlE.branch & branchCond) | ctrlE.jump;
  assign PCJalSrcE = ctrlE.jump & ctrlE.jalr;

  assign latE    = ctrlE.funct3[2] ? DIV_L : MUL_L;
  assign longOpE = MulDivE && (latE > 6'd1);

  // Timer state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Timer next state and BusyE; cnt keeps running under StallE, a flush aborts it
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    BusyE     = 1'b0;
    case (state)
      IDLE: begin
        if (longOpE) begin
          BusyE     = 1'b1;
          stateNext = BUSY;
          cntNext   = 5'(latE - 6'd2);
        end
      end
      BUSY: begin
        BusyE = (cnt != 5'd0);
        if (cnt != 5'd0) begin
          cntNext = cnt - 5'd1;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (FlushE) begin
      stateNext = IDLE;
      cntNext   = 5'd0;
    end
  end

  // M and W registers; a busy E stage sends a bubble down the pipe
  always_ff @(posedge clk) begin
    if (!reset) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      resultSrcM <= 2'b00;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
    end else begin
      if (BusyE) begin
        RegWriteM  <= 1'b0;
        MemWriteM  <= 1'b0;
        resultSrcM <= 2'b00;
      end else begin
        RegWriteM  <= ctrlE.regWrite;
        MemWriteM  <= ctrlE.memWrite;
        resultSrcM <= ctrlE.resultSrc;
      end
      RegWriteW  <= RegWriteM;
      ResultSrcW <= resultSrcM;
    end
  end

endmodule

// File: doc/pipe_controller_md.md
PIPE_CONTROLLER_MD -- requirements
Module: pipe_controller_md

Interface
REQ-001 SHALL have parameter DIV_LATENCY, default 8, meaning E-stage occupancy in cycles of DIV/DIVU/REM/REMU (legal range 1..32).
REQ-002 SHALL have parameter MUL_LATENCY, default 1, meaning E-stage occupancy in cycles of MUL/MULH/MULHSU/MULHU (legal range 1..32).
REQ-003 SHALL have ports (name, direction, width, meaning), clock and reset first:
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-low reset (0 = reset at clk edge)
  op  in  7  D-stage opcode
  funct3  in  3  D-stage funct3
  funct7  in  7  D-stage funct7
  ZeroE  in  1  ALU result == 0
  LtE  in  1  signed SrcA < SrcB
  LtuE  in  1  unsigned SrcA < SrcB
  StallE  in  1  hazard-unit hold of E register
  FlushE  in  1  hazard-unit bubble into E register
  ImmSrcD  out  3  immediate type: I 000, S 001, B 010, J 011, U 100
  ALUControlE  out  5  registered ALU op
  ALUSrcAE  out  1  1 = PC as SrcA (auipc, jal)
  ALUSrcBE  out  2  00 reg, 01 imm, 10 zero (lui)
  ResultSrcE0  out  1  ResultSrcE[0], load-use detection
  PCSrcE  out  1  redirect PC (taken branch or jump)
  PCJalSrcE  out  1  redirect target from ALU (jalr)
  MulDivE  out  1  M-extension op in E
  BusyE  out  1  multi-cycle op needs more cycles; hazard unit stalls F/D
  MemWriteM, RegWriteM  out  1 each  M-stage controls
  RegWriteW  out  1  W-stage write enable
  ResultSrcW  out  2  00 ALU, 01 mem, 10 PC+4

Function
REQ-004 SHALL decode op combinationally in D: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111; any other op yields all-zero controls (bubble).
REQ-005 SHALL form ALUControlD = {muldiv, alt, funct3}: muldiv=1 only for R with funct7=0000001; alt = funct7[5] for R add/sub and srl/sra, for I only when funct3=101; branches 01000; loads/stores/jal/jalr/lui/auipc 00000.
REQ-006 SHALL register into E: RegWrite, MemWrite, Jump, Branch, Jalr, ALUSrcA, ALUSrcB, ResultSrc, ALUControl and funct3 (branch evaluation uses funct3E, never D-stage funct3).
REQ-007 SHALL evaluate taken = BranchE & f(funct3E): 000 ZeroE, 001 !ZeroE, 100 LtE, 101 !LtE, 110 LtuE, 111 !LtuE, 010/011 never taken; PCSrcE = taken | JumpE; PCJalSrcE = JumpE & JalrE.
REQ-008 SHALL, per edge, update E register with priority reset > FlushE (all zero) > hold (StallE | BusyE) > load D.
REQ-009 SHALL use latency L = DIV_LATENCY when MulDivE & funct3E[2], MUL_LATENCY when MulDivE & !funct3E[2].
REQ-010 SHALL implement FSM IDLE/BUSY with down-counter cnt (5 bits): IDLE with MulDivE and L>1 -> BusyE=1, next BUSY, cnt<=L-2; BUSY -> BusyE=(cnt!=0), cnt decrements while nonzero; BUSY with cnt==0 -> BusyE=0, next IDLE.
REQ-011 SHALL hold an L-cycle op in E for exactly L cycles; L=1 never asserts BusyE.
REQ-012 SHALL insert a bubble into M (RegWriteM=0, MemWriteM=0, ResultSrcM=00) on every edge where BusyE=1; E->M otherwise unconditional, M->W unconditional.
REQ-013 SHALL, on FlushE while BUSY, abort: state IDLE, cnt 0, E cleared; StallE during BUSY SHALL not pause cnt.
REQ-014 SHALL keep PCSrcE/PCJalSrcE purely combinational from E register and flags (no extra latency).

Reset
REQ-015 SHALL, when reset=0 at a rising clk edge, clear E, M, W registers, set state IDLE, cnt 0; all registered outputs, PCSrcE, PCJalSrcE, BusyE, MulDivE read 0 the following cycle.
REQ-016 SHALL let reset=0 abort an in-flight multi-cycle op with no residual BusyE after release.

Verification
REQ-017 bne with ZeroE=1 then ZeroE=0 in E -> PCSrcE 0 then 1; D-stage funct3 toggled to 000 same cycle has no effect.
REQ-018 bgeu in E, LtuE=0 -> PCSrcE=1; blt, LtE=0 -> PCSrcE=0; funct3E=010 -> 0.
REQ-019 div (funct7=0000001, funct3=100), DIV_LATENCY=8 -> BusyE=1 for 7 cycles, 0 on 8th, RegWriteM=0 for 7 edges, then RegWriteM=1 once.
REQ-020 mul with MUL_LATENCY=1 -> BusyE never 1, RegWriteM=1 next cycle.
REQ-021 FlushE in cycle 3 of div -> BusyE=0 next cycle, E zero, RegWriteM stays 0.
REQ-022 reset=0 for one edge mid-div, then add -> all outputs 0, add passes with BusyE=0 and RegWriteW=1 three edges after entering E.
